// File: rtl/psum_drain.sv
// Accumulator-side sequencer for the output-stationary MAC array: times a pass,
// snapshots the accumulators, streams them row-major on valid/ready, then clears the array.
module psum_drain #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int BW      = 8,
  parameter int K_MAX   = 8,
  parameter int BW_PSUM = 2*BW + $clog2(K_MAX)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic [ROWS*COLS*BW_PSUM-1:0]  accum_in,
  output logic                          arr_clr,
  output logic [BW_PSUM-1:0]            out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic [$clog2(COLS)-1:0]       out_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(K_MAX + ROWS + COLS);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, CLEAR} state_t;

  state_t             state, state_nx;
  logic [TW-1:0]      cnt;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic [BW_PSUM-1:0] snap [ROWS][COLS];
  logic               at_end;
  logic               capture;
  logic               beat_hs;

  assign at_end  = (row == RW'(ROWS-1)) && (col == CW'(COLS-1));
  assign capture = (state == WAIT) && (cnt == TW'(1));
  assign beat_hs = out_valid && out_ready;
  assign out_row = row;
  assign out_col = col;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    arr_clr   = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (k_len == '0) ? CLEAR : WAIT;
      end
      WAIT: begin
        if (cnt == TW'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = snap[row][col];
        out_last  = at_end;
        if (out_ready && at_end) state_nx = CLEAR;
      end
      CLEAR: begin
        arr_clr  = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Array is held clear for as long as reset is asserted.
    if (!rst) arr_clr = 1'b1;
  end

  // Wait counter and drain index; the counter load doubles as the k_len latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      row <= '0;
      col <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (k_len != '0))
            cnt <= TW'(k_len) + TW'(ROWS + COLS - 1);
        end
        WAIT: begin
          cnt <= cnt - TW'(1);
          if (capture) begin
            row <= '0;
            col <= '0;
          end
        end
        DRAIN: begin
          if (beat_hs) begin
            if (col == CW'(COLS-1)) begin
              col <= '0;
              row <= at_end ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < ROWS; i++)
        for (int unsigned j = 0; j < COLS; j++)
          snap[i][j] <= accum_in[(i*COLS + j)*BW_PSUM +: BW_PSUM];
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: expected beats queued when accum_in/start are driven,
// popped and compared on each accepted beat.
module tb_psum_drain;

  localparam int ROWS = 4, COLS = 4, BWP = 19;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [3:0]                k_len;
  logic [ROWS*COLS*BWP-1:0]  accum_in;
  logic                      arr_clr;
  logic [BWP-1:0]            out_data;
  logic [1:0]                out_row;
  logic [1:0]                out_col;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  typedef struct packed {
    logic [BWP-1:0] d;
    logic [1:0]     r;
    logic [1:0]     c;
    logic           l;
  } beat_t;

  beat_t q[$];
  int nerr = 0;
  int nchk = 0;

  psum_drain #(.ROWS(4), .COLS(4), .BW(8), .K_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accum_in(accum_in),
    .arr_clr(arr_clr), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pat 0: out_ready always 1; pat 1: out_ready 1,0,0,1 repeating.
  task automatic run_pass(input int k, input int base, input int pat, input bit corrupt,
                          input bit poke, input int rst_beat, input int exp_end);
    int   cyc;
    int   hs;
    beat_t b;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        b.d = BWP'(16*i + j + 1 + base);
        b.r = 2'(i);
        b.c = 2'(j);
        b.l = (i == ROWS-1) && (j == COLS-1);
        accum_in[(i*COLS + j)*BWP +: BWP] = b.d;
        q.push_back(b);
      end
    k_len = 4'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    hs  = 0;
    while (q.size() > 0 && cyc < 200) begin
      out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start     = poke && (cyc == 5 || cyc == 20);
      if (corrupt && cyc == k + ROWS + COLS) accum_in = '1 >> 1 ;
      if (corrupt && cyc == k + ROWS + COLS)
        for (int n = 0; n < ROWS*COLS; n++) accum_in[n*BWP +: BWP] = 19'h7FFFF;
      @(negedge clk);
      chk("valid", {31'd0, out_valid}, {31'd0, cyc >= k + ROWS + COLS});
      if (out_valid) begin
        chk("data", {13'd0, out_data}, {13'd0, q[0].d});
        chk("row",  {30'd0, out_row},  {30'd0, q[0].r});
        chk("col",  {30'd0, out_col},  {30'd0, q[0].c});
        chk("last", {31'd0, out_last}, {31'd0, q[0].l});
        if (out_ready) begin
          void'(q.pop_front());
          hs++;
        end
      end
      if (rst_beat >= 0 && hs == rst_beat) begin
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clr_async", {31'd0, arr_clr}, 32'd1);
        @(posedge clk); #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_clr",   {31'd0, arr_clr},   32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_clr",   {31'd0, arr_clr},   32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk("beats_left", 32'(q.size()), 32'd0);
    if (exp_end > 0) chk("end_cycle", 32'(cyc), 32'(exp_end));
    @(negedge clk);
    chk("clr_pulse",  {31'd0, arr_clr},   32'd1);
    chk("done_pulse", {31'd0, done},      32'd1);
    chk("clr_valid",  {31'd0, out_valid}, 32'd0);
    chk("clr_busy",   {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy},    32'd0);
    chk("idle_done", {31'd0, done},    32'd0);
    chk("idle_clr",  {31'd0, arr_clr}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; k_len = 4'd0; out_ready = 1'b1;
    accum_in = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", {31'd0, out_valid}, 32'd0);
    chk("rst_last0",  {31'd0, out_last},  32'd0);
    chk("rst_done0",  {31'd0, done},      32'd0);
    chk("rst_busy0",  {31'd0, busy},      32'd0);
    chk("rst_clr0",   {31'd0, arr_clr},   32'd1);
    chk("rst_data0",  {13'd0, out_data},  32'd0);
    chk("rst_row0",   {30'd0, out_row},   32'd0);
    chk("rst_col0",   {30'd0, out_col},   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Baseline pass: capture at edge 15, beats cycles 16..31, clear at 32.
    run_pass(8, 0, 0, 1'b0, 1'b0, -1, 32);
    // Stalled handshakes.
    run_pass(8, 100, 1, 1'b0, 1'b0, -1, 0);
    // accum_in overwritten right after the capture edge.
    run_pass(8, 200, 0, 1'b1, 1'b0, -1, 32);
    // start pulses during WAIT and DRAIN are ignored.
    run_pass(8, 300, 0, 1'b0, 1'b1, -1, 32);
    // Shorter reduction length.
    run_pass(3, 400, 0, 1'b0, 1'b0, -1, 27);

    // k_len = 0 goes straight to CLEAR.
    k_len = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("k0_clr",   {31'd0, arr_clr},   32'd1);
    chk("k0_done",  {31'd0, done},      32'd1);
    chk("k0_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("k0_busy",  {31'd0, busy},      32'd0);
    chk("k0_valid2",{31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset after five accepted beats, then a fresh pass drains from (0,0).
    run_pass(8, 500, 0, 1'b0, 1'b0, 5, 0);
    @(posedge clk); #1;
    run_pass(8, 600, 0, 1'b0, 1'b0, -1, 32);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
